axa_execute: RTL
================

# axa_execute

Execute/write-back stage of the AXA multi-cycle processor, directly downstream of the fetch/decode/operand-select sequencer. Accepts one decoded instruction at a time (opcode, destination index, resolved source operand) and computes the ALU result. Writes the owned 16×16 register file, then reports branch redirects, `ex` memory writes and halt conditions back to the sequencer.

## Interface
- `WIDTH`, 16, datapath and register width
- `NREGS`, 16, register count; the destination index is log2(NREGS) bits
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low
- `in_valid` in 1: decoded instruction presented
- `in_ready` out 1: stage can accept; high only in IDLE
- `is_i8` in 1: 8-bit-immediate format; the opcode is in `op[3:0]`
- `op` in 6: AXA opcode (OPadd…OPdup; OP8 codes when `is_i8`)
- `dst` in 4: destination register index
- `src_val` in 16: operand, already sign-extended by decode
- `src_is_imm` in 1: operand came from an immediate
- `pc_in` in 16: address of the next sequential instruction
- `mem_rdata` in 16: unused except by `ex`; equals the current value of datamem[`mem_addr`]
- `src_addr` in 16: memory address of the source (`ex` only)
- `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16: data-memory write
- `pc_load` out 1, `pc_next` out 16: branch redirect
- `done` out 1: one-cycle retire pulse
- `halt` out 1: sticky halt
- `err` out 1: sticky error flag

## Operation
- FSM states: IDLE, EXEC, WB, HALT.
- IDLE: `in_ready`=1. When `in_valid`, latch all inputs and go to EXEC.
- EXEC: read d=R[dst] and compute into a result register. Then go to WB, or to HALT for OPsys, OPfail or any undefined opcode.
- Result rules, all mod 2^16:
  - add d+s; sub d−s; xor d^s; or d|s; and d&s
  - shr: d>>s[3:0], logical
  - rol: d rotated left by s[3:0]; a rotation of 0 yields d
  - dup: d←s; com: d←~d
  - xhi: d^(s[7:0]<<8); xlo: d^{8'h00,s[7:0]}
  - lhi: {s[7:0],8'h00}; llo: sign-extended s[7:0]
- ex: R[dst]←`mem_rdata`, `mem_addr`=`src_addr`, `mem_wdata`=old d.
- Branches (bz d==0, bnz d!=0, bn d[15], bnn !d[15]):
  - Target is `pc_in`+`src_val` when `src_is_imm`, otherwise `src_val`.
  - No register write.
- land and com-class no-ops: land performs no write.
- WB: when applicable, write R[dst] and pulse `mem_we`. When a branch is taken, assert `pc_load`. Pulse `done`, then return to IDLE.
- HALT: `halt`=1, `in_ready`=0. Only reset exits this state.
- Reset (any state, including mid-operation):
  - state→IDLE; all registers→0
  - all outputs 0 except `in_ready`=1
  - a pending write-back is discarded

## Timing
- Accept on edge N; result registered at N+1; `done`/`pc_load`/`mem_we`/register write on edge N+2 (valid during cycle N+2). Throughput: one instruction every 3 cycles.
- `mem_we`, `pc_load` and `done` are single-cycle pulses coincident with the WB cycle. `pc_next` holds its value until the next taken branch.
- `in_valid` is ignored outside IDLE. The sequencer must hold its inputs only for the accept cycle.
- A write to R[dst] is visible to the next instruction's EXEC read, with no hazard window.
- `halt` rises on the edge after EXEC of a halting opcode. `done` is not pulsed for that instruction.

## Configuration
- `AXA_ERR_EN` defined:
  - add/sub signed overflow sets `err` in WB; it stays set until reset.
  - jerr branches (same target rule as other branches) when `err`=1, and clears `err` on that taken jump.
- `AXA_ERR_EN` undefined:
  - `err` is tied to 0.
  - jerr retires as a no-op: `done` pulses, nothing is written, no branch is taken.

## Structure
- Shared package `axa_pkg`: opcode constants (6-bit and OP8), FSM state encoding, `WIDTH` default.
- Sub-module `axa_regfile`: NREGS×WIDTH, one combinational read port, one synchronous write port, async active-low clear.
- ALU, branch evaluation and FSM stay in `axa_execute`.

## Test plan
- R1=5, `op`=add, `src_val`=3, dst=1 → `done` at N+2, R1=8, `pc_load`=0.
- R2=0x8001, rol by `src_val`=1 → R2=0x0003; rol by 0 leaves R2=0x8001.
- R3=0, bz with `src_is_imm`, `pc_in`=0x0010, `src_val`=0xFFFE → `pc_load`=1, `pc_next`=0x000E. R3=1 with the same instruction → `pc_load`=0.
- ex with R4=0x1234, `src_addr`=0x0020, `mem_rdata`=0xBEEF → `mem_we` pulse, addr 0x0020, wdata 0x1234, R4=0xBEEF.
- `AXA_ERR_EN`: R5=0x7FFF add 1 → R5=0x8000, `err`=1. Then jerr reg `src_val`=0x0040 → `pc_next`=0x0040, `err`=0.
- OPfail → `halt`=1 and `in_ready`=0 after EXEC. Reset asserted mid-EXEC of an add → no write, outputs at reset values, IDLE.

Source files
------------

// File: rtl/axa_pkg.sv
// Shared AXA definitions: opcode encodings (6-bit and 8-bit-immediate forms),
// execute-stage FSM states, internal ALU operation codes and the opcode decoder.
package axa_pkg;
    localparam int AXA_WIDTH = 16;

    localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_XOR  = 6'd2,  OP_OR   = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd4,  OP_SHR  = 6'd5,  OP_ROL  = 6'd6,  OP_DUP  = 6'd7;
    localparam logic [5:0] OP_COM  = 6'd8,  OP_XHI  = 6'd9,  OP_XLO  = 6'd10, OP_LHI  = 6'd11;
    localparam logic [5:0] OP_LLO  = 6'd12, OP_EX   = 6'd13, OP_BZ   = 6'd14, OP_BNZ  = 6'd15;
    localparam logic [5:0] OP_BN   = 6'd16, OP_BNN  = 6'd17, OP_JERR = 6'd18, OP_LAND = 6'd19;
    localparam logic [5:0] OP_SYS  = 6'd20, OP_FAIL = 6'd21;

    localparam logic [3:0] OP8_LHI = 4'd0, OP8_LLO = 4'd1, OP8_XHI = 4'd2, OP8_XLO = 4'd3;
    localparam logic [3:0] OP8_ADD = 4'd4, OP8_BZ  = 4'd5, OP8_BNZ = 4'd6, OP8_BN  = 4'd7;
    localparam logic [3:0] OP8_BNN = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_e;

    typedef enum logic [4:0] {
        A_ADD, A_SUB, A_XOR, A_OR, A_AND, A_SHR, A_ROL, A_DUP, A_COM, A_XHI, A_XLO,
        A_LHI, A_LLO, A_EX, A_BZ, A_BNZ, A_BN, A_BNN, A_JERR, A_LAND, A_HALT
    } alu_e;

    // Both encodings collapse onto one internal operation; anything unknown halts.
    function automatic alu_e decode_op(input logic is_i8, input logic [5:0] op);
        alu_e a;
        a = A_HALT;
        if (is_i8) begin
            case (op[3:0])
                OP8_LHI: a = A_LHI;
                OP8_LLO: a = A_LLO;
                OP8_XHI: a = A_XHI;
                OP8_XLO: a = A_XLO;
                OP8_ADD: a = A_ADD;
                OP8_BZ:  a = A_BZ;
                OP8_BNZ: a = A_BNZ;
                OP8_BN:  a = A_BN;
                OP8_BNN: a = A_BNN;
                default: a = A_HALT;
            endcase
        end else begin
            case (op)
                OP_ADD:  a = A_ADD;
                OP_SUB:  a = A_SUB;
                OP_XOR:  a = A_XOR;
                OP_OR:   a = A_OR;
                OP_AND:  a = A_AND;
                OP_SHR:  a = A_SHR;
                OP_ROL:  a = A_ROL;
                OP_DUP:  a = A_DUP;
                OP_COM:  a = A_COM;
                OP_XHI:  a = A_XHI;
                OP_XLO:  a = A_XLO;
                OP_LHI:  a = A_LHI;
                OP_LLO:  a = A_LLO;
                OP_EX:   a = A_EX;
                OP_BZ:   a = A_BZ;
                OP_BNZ:  a = A_BNZ;
                OP_BN:   a = A_BN;
                OP_BNN:  a = A_BNN;
                OP_JERR: a = A_JERR;
                OP_LAND: a = A_LAND;
                OP_SYS, OP_FAIL: a = A_HALT;
                default: a = A_HALT;
            endcase
        end
        return a;
    endfunction
endpackage

// File: rtl/axa_regfile.sv
// AXA register file: NREGS x WIDTH, combinational read, synchronous write,
// asynchronous active-low clear.
module axa_regfile
    import axa_pkg::*;
#(
    parameter int WIDTH = AXA_WIDTH,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];
endmodule

// File: rtl/axa_execute.sv
// AXA execute/write-back stage: IDLE -> EXEC -> WB (or HALT), ALU, branches, register file.
// Define AXA_ERR_EN to enable sticky add/sub overflow tracking in err and the jerr branch.
module axa_execute
    import axa_pkg::*;
#(
    parameter int WIDTH = AXA_WIDTH,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     is_i8,
    input  logic [5:0]               op,
    input  logic [$clog2(NREGS)-1:0] dst,
    input  logic [WIDTH-1:0]         src_val,
    input  logic                     src_is_imm,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic [WIDTH-1:0]         src_addr,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    output logic                     pc_load,
    output logic [WIDTH-1:0]         pc_next,
    output logic                     done,
    output logic                     halt,
    output logic                     err
);
    localparam int AW = $clog2(NREGS);

    state_e             state, state_nx;
    alu_e               alu_q;
    logic [AW-1:0]      dst_q;
    logic [WIDTH-1:0]   src_q, pc_q, res_q, res_d, d, tgt;
    logic [2*WIDTH-1:0] rot;
    logic               imm_q, wr_q, wr_d, mwe_q, br_q, taken, rf_we;
`ifdef AXA_ERR_EN
    logic               ovf_d, ovf_q, err_q;
`endif

    axa_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .we(rf_we), .waddr(dst_q), .wdata(res_q),
        .raddr(dst_q), .rdata(d)
    );

    always_comb begin
        rot   = {d, d} << src_q[3:0];
        res_d = d;
        wr_d  = 1'b1;
        taken = 1'b0;
        tgt   = imm_q ? pc_q + src_q : src_q;
`ifdef AXA_ERR_EN
        ovf_d = 1'b0;
`endif
        case (alu_q)
            A_ADD: begin
                res_d = d + src_q;
`ifdef AXA_ERR_EN
                ovf_d = (d[WIDTH-1] == src_q[WIDTH-1]) && (res_d[WIDTH-1] != d[WIDTH-1]);
`endif
            end
            A_SUB: begin
                res_d = d - src_q;
`ifdef AXA_ERR_EN
                ovf_d = (d[WIDTH-1] != src_q[WIDTH-1]) && (res_d[WIDTH-1] != d[WIDTH-1]);
`endif
            end
            A_XOR:  res_d = d ^ src_q;
            A_OR:   res_d = d | src_q;
            A_AND:  res_d = d & src_q;
            A_SHR:  res_d = d >> src_q[3:0];
            A_ROL:  res_d = rot[2*WIDTH-1:WIDTH];
            A_DUP:  res_d = src_q;
            A_COM:  res_d = ~d;
            A_XHI:  res_d = d ^ WIDTH'({src_q[7:0], 8'h00});
            A_XLO:  res_d = d ^ WIDTH'(src_q[7:0]);
            A_LHI:  res_d = WIDTH'({src_q[7:0], 8'h00});
            A_LLO:  res_d = {{(WIDTH-8){src_q[7]}}, src_q[7:0]};
            A_EX:   res_d = mem_rdata;
            A_BZ:   begin wr_d = 1'b0; taken = (d == '0);      end
            A_BNZ:  begin wr_d = 1'b0; taken = (d != '0);      end
            A_BN:   begin wr_d = 1'b0; taken = d[WIDTH-1];     end
            A_BNN:  begin wr_d = 1'b0; taken = !d[WIDTH-1];    end
`ifdef AXA_ERR_EN
            A_JERR: begin wr_d = 1'b0; taken = err_q;          end
`else
            A_JERR: wr_d = 1'b0;
`endif
            default: wr_d = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        halt     = 1'b0;
        mem_we   = 1'b0;
        pc_load  = 1'b0;
        rf_we    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = (alu_q == A_HALT) ? S_HALT : S_WB;
            S_WB: begin
                done     = 1'b1;
                mem_we   = mwe_q;
                pc_load  = br_q;
                rf_we    = wr_q;
                state_nx = S_IDLE;
            end
            S_HALT: halt = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            alu_q     <= A_ADD;
            dst_q     <= '0;
            src_q     <= '0;
            pc_q      <= '0;
            imm_q     <= 1'b0;
            res_q     <= '0;
            wr_q      <= 1'b0;
            mwe_q     <= 1'b0;
            br_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc_next   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid) begin
                alu_q    <= decode_op(is_i8, op);
                dst_q    <= dst;
                src_q    <= src_val;
                pc_q     <= pc_in;
                imm_q    <= src_is_imm;
                mem_addr <= src_addr;
            end
            if (state == S_EXEC) begin
                res_q <= res_d;
                wr_q  <= wr_d;
                mwe_q <= (alu_q == A_EX);
                br_q  <= taken;
                if (alu_q == A_EX) mem_wdata <= d;
                if (taken)         pc_next   <= tgt;
            end
        end
    end

`ifdef AXA_ERR_EN
    // err changes on the edge that ends WB, alongside the register write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state == S_EXEC) ovf_q <= ovf_d;
            if (state == S_WB) begin
                if (br_q && alu_q == A_JERR) err_q <= 1'b0;
                else if (ovf_q)              err_q <= 1'b1;
            end
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
